// File: rtl/obj_draw_ctrl.sv
// obj_draw_ctrl: accepts a "place object at (x,y)" request, erases the
// previously drawn box with the background colour, then draws the box at the
// new position. One registered pixel write per clock towards the VGA adapter.
module obj_draw_ctrl #(
    parameter int          OBJ_W     = 4,
    parameter int          OBJ_H     = 4,
    parameter int          SCREEN_W  = 160,
    parameter int          SCREEN_H  = 120,
    parameter logic [2:0]  BG_COLOUR = 3'd0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    input  logic       req_erase_only,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

    // Last column/row index of the box; counters are 4 bits since the box is at most 16x16.
    localparam logic [3:0] COL_LAST = 4'(OBJ_W - 1);
    localparam logic [3:0] ROW_LAST = 4'(OBJ_H - 1);

    state_t     state_reg, state_next;
    logic [3:0] col_reg, row_reg;
    logic       pix_last;
    logic       in_phase;

    // Request latched at ack time
    logic [7:0] new_x_reg;
    logic [6:0] new_y_reg;
    logic [2:0] new_colour_reg;
    logic       erase_only_reg;

    // Position of the box currently on screen
    logic [7:0] old_x_reg;
    logic [6:0] old_y_reg;
    logic       drawn_valid_reg;

    // Registered pixel outputs
    logic       plot_reg;
    logic       done_reg;
    logic [7:0] x_reg;
    logic [6:0] y_reg;
    logic [2:0] colour_reg;

    // Unwrapped pixel coordinates, one bit wider than the screen bus so that
    // pixels running off the right/bottom edge are detected rather than wrapped.
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       pix_on;
    logic [2:0] phase_colour;

    assign in_phase = (state_reg == ERASE) || (state_reg == DRAW);
    assign pix_last = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

    // Select base position and colour for the active phase and form the pixel address.
    always_comb begin
        base_x       = new_x_reg;
        base_y       = new_y_reg;
        phase_colour = new_colour_reg;
        if (state_reg == ERASE) begin
            base_x       = old_x_reg;
            base_y       = old_y_reg;
            phase_colour = BG_COLOUR;
        end
        sum_x  = {1'b0, base_x} + {5'b0, col_reg};
        sum_y  = {1'b0, base_y} + {4'b0, row_reg};
        pix_on = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the combinational ack handshake.
    always_comb begin
        state_next = state_reg;
        ack        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req && resetn) begin
                    ack = 1'b1;
                    if (drawn_valid_reg) begin
                        state_next = ERASE;
                    end else if (req_erase_only) begin
                        state_next = FINISH;
                    end else begin
                        state_next = DRAW;
                    end
                end
            end
            ERASE: begin
                if (pix_last) begin
                    state_next = erase_only_reg ? FINISH : DRAW;
                end
            end
            DRAW: begin
                if (pix_last) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Raster counter: column fastest, restarts at every phase boundary.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (in_phase) begin
            if (pix_last) begin
                col_reg <= '0;
                row_reg <= '0;
            end else if (col_reg == COL_LAST) begin
                col_reg <= '0;
                row_reg <= row_reg + 4'd1;
            end else begin
                col_reg <= col_reg + 4'd1;
            end
        end else begin
            col_reg <= '0;
            row_reg <= '0;
        end
    end

    // Capture the request when it is acknowledged.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            new_x_reg      <= '0;
            new_y_reg      <= '0;
            new_colour_reg <= '0;
            erase_only_reg <= 1'b0;
        end else if (ack) begin
            new_x_reg      <= req_x;
            new_y_reg      <= req_y;
            new_colour_reg <= req_colour;
            erase_only_reg <= req_erase_only;
        end
    end

    // Remember what is on screen once the sequence completes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            old_x_reg       <= '0;
            old_y_reg       <= '0;
            drawn_valid_reg <= 1'b0;
        end else if (state_reg == FINISH) begin
            drawn_valid_reg <= !erase_only_reg;
            if (!erase_only_reg) begin
                old_x_reg <= new_x_reg;
                old_y_reg <= new_y_reg;
            end
        end
    end

    // Registered pixel stream; coordinates hold between phases.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            plot_reg   <= 1'b0;
            done_reg   <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
        end else begin
            plot_reg <= in_phase && pix_on;
            done_reg <= (state_reg == FINISH);
            if (in_phase) begin
                x_reg      <= sum_x[7:0];
                y_reg      <= sum_y[6:0];
                colour_reg <= phase_colour;
            end
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign plot   = plot_reg;
    assign x      = x_reg;
    assign y      = y_reg;
    assign colour = colour_reg;

endmodule

// File: tb/tb_obj_draw_ctrl.sv
// Directed bench for obj_draw_ctrl: table of requests with hand-computed
// latency/plot expectations, plus sequences for held req and mid-draw reset.
module tb_obj_draw_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       req = 1'b0;
    logic [7:0] req_x = '0;
    logic [6:0] req_y = '0;
    logic [2:0] req_colour = '0;
    logic       req_erase_only = 1'b0;
    logic       ack, busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    obj_draw_ctrl dut (
        .clock(clock), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .req_erase_only(req_erase_only),
        .ack(ack), .busy(busy), .done(done), .plot(plot),
        .x(x), .y(y), .colour(colour)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic [7:0] rx;
        logic [6:0] ry;
        logic [2:0] rc;
        logic       eo;
        int         exp_lat;
        int         exp_n;
        logic [7:0] fx; logic [6:0] fy; logic [2:0] fc;
        logic [7:0] lx; logic [6:0] ly; logic [2:0] lc;
    } vec_t;

    vec_t vecs [8];

    int cyc = 0;
    int ack_total = 0;
    int plot_q [$];
    int plot_cyc [$];
    int exp_q [$];
    int n_pass = 0;
    int n_total = 0;

    // Bench model of what is on screen
    logic       m_valid = 1'b0;
    int         m_ox = 0;
    int         m_oy = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every plotted pixel and count acks, sampled mid-cycle.
    always @(negedge clock) begin
        if (plot) begin
            plot_q.push_back({14'b0, x, y, colour});
            plot_cyc.push_back(cyc);
        end
        if (ack) ack_total <= ack_total + 1;
    end

    function automatic int pk(input int px, input int py, input int pc);
        return (px << 10) | (py << 3) | pc;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Build the expected pixel stream of one request from the screen model.
    task automatic build_expected(input int nx, input int ny, input int nc, input logic eo);
        exp_q.delete();
        if (m_valid)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (m_ox + c < 160 && m_oy + r < 120) exp_q.push_back(pk(m_ox + c, m_oy + r, 0));
        if (!eo)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (nx + c < 160 && ny + r < 120) exp_q.push_back(pk(nx + c, ny + r, nc));
    endtask

    task automatic wait_ack(output int ack_cyc);
        bit got = 0;
        ack_cyc = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (ack) begin got = 1; ack_cyc = cyc; end
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_done(output int done_cyc);
        bit got = 0;
        done_cyc = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (done) begin got = 1; done_cyc = cyc; end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic check_raster(input string name, input int p0);
        int ok = (plot_q.size() - p0 == exp_q.size()) ? 1 : 0;
        if (ok == 1)
            for (int i = 0; i < exp_q.size(); i++)
                if (plot_q[p0 + i] != exp_q[i]) ok = 0;
        chk(name, ok, 1);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int ack0, p0, a_cyc, d_cyc;
        v = vecs[idx];
        @(posedge clock); #1;
        ack0 = ack_total;
        p0 = plot_q.size();
        build_expected(int'(v.rx), int'(v.ry), int'(v.rc), v.eo);
        req = 1'b1; req_x = v.rx; req_y = v.ry; req_colour = v.rc; req_erase_only = v.eo;
        wait_ack(a_cyc);
        @(posedge clock); #1;
        req = 1'b0;
        wait_done(d_cyc);
        chk($sformatf("v%0d_done_lat", idx), d_cyc - a_cyc, v.exp_lat);
        @(posedge clock); #1;
        chk($sformatf("v%0d_ack_pulses", idx), ack_total - ack0, 1);
        chk($sformatf("v%0d_nplots", idx), plot_q.size() - p0, v.exp_n);
        chk($sformatf("v%0d_busy_after", idx), int'(busy), 0);
        if (v.exp_n > 0 && plot_q.size() > p0) begin
            chk($sformatf("v%0d_first_lat", idx), plot_cyc[p0] - a_cyc, 2);
            chk($sformatf("v%0d_first_pix", idx), plot_q[p0], pk(int'(v.fx), int'(v.fy), int'(v.fc)));
            chk($sformatf("v%0d_last_pix", idx), plot_q[plot_q.size() - 1], pk(int'(v.lx), int'(v.ly), int'(v.lc)));
        end
        check_raster($sformatf("v%0d_raster", idx), p0);
        $display("vec %0d: req (%0d,%0d) col %0d eo %0d -> done +%0d, %0d plots",
                 idx, v.rx, v.ry, v.rc, v.eo, d_cyc - a_cyc, plot_q.size() - p0);
        if (v.eo) m_valid = 1'b0;
        else begin m_valid = 1'b1; m_ox = int'(v.rx); m_oy = int'(v.ry); end
    endtask

    initial begin
        int ack0, p0, a_cyc, d_cyc, a2_cyc;
        //           rx   ry   rc  eo  lat  n   first            last
        vecs[0] = '{8'd0,   7'd0,   3'd1, 1'b1, 2,  0,  8'd0,   7'd0,   3'd0, 8'd0,   7'd0,   3'd0};
        vecs[1] = '{8'd10,  7'd58,  3'd2, 1'b0, 18, 16, 8'd10,  7'd58,  3'd2, 8'd13,  7'd61,  3'd2};
        vecs[2] = '{8'd11,  7'd58,  3'd2, 1'b0, 34, 32, 8'd10,  7'd58,  3'd0, 8'd14,  7'd61,  3'd2};
        vecs[3] = '{8'd158, 7'd118, 3'd5, 1'b0, 34, 20, 8'd11,  7'd58,  3'd0, 8'd159, 7'd119, 3'd5};
        vecs[4] = '{8'd20,  7'd30,  3'd3, 1'b0, 34, 20, 8'd158, 7'd118, 3'd0, 8'd23,  7'd33,  3'd3};
        vecs[5] = '{8'd0,   7'd0,   3'd1, 1'b1, 18, 16, 8'd20,  7'd30,  3'd0, 8'd23,  7'd33,  3'd0};
        vecs[6] = '{8'd5,   7'd6,   3'd4, 1'b0, 18, 16, 8'd5,   7'd6,   3'd4, 8'd8,   7'd9,   3'd4};
        vecs[7] = '{8'd30,  7'd40,  3'd2, 1'b0, 18, 16, 8'd30,  7'd40,  3'd2, 8'd33,  7'd43,  3'd2};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        $display("reset: ack %0d busy %0d done %0d plot %0d x %0d y %0d colour %0d", ack, busy, done, plot, x, y, colour);
        @(posedge clock); #1;
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // req held high through busy with a changing req_x
        @(posedge clock); #1;
        ack0 = ack_total;
        p0 = plot_q.size();
        req = 1'b1; req_x = 8'd40; req_y = 7'd10; req_colour = 3'd6; req_erase_only = 1'b0;
        wait_ack(a_cyc);
        @(posedge clock); #1;
        req_x = 8'd50;
        wait_done(d_cyc);
        chk("held_done_lat", d_cyc - a_cyc, 34);
        chk("held_reaccept", int'(ack), 1);
        a2_cyc = d_cyc;
        @(posedge clock); #1;
        req = 1'b0;
        chk("held_ack_count", ack_total - ack0, 2);
        wait_done(d_cyc);
        chk("held2_done_lat", d_cyc - a2_cyc, 34);
        @(posedge clock); #1;
        chk("held_nplots", plot_q.size() - p0, 64);
        if (plot_q.size() - p0 == 64) begin
            chk("held2_first_erase", plot_q[p0 + 32], pk(40, 10, 0));
            chk("held2_last_pix", plot_q[p0 + 63], pk(53, 13, 6));
        end
        $display("held req: second request drawn, %0d plots total", plot_q.size() - p0);
        m_valid = 1'b1; m_ox = 50; m_oy = 10;

        // Reset in the middle of the DRAW phase
        @(posedge clock); #1;
        req = 1'b1; req_x = 8'd70; req_y = 7'd20; req_colour = 3'd7; req_erase_only = 1'b0;
        wait_ack(a_cyc);
        @(posedge clock); #1;
        req = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        chk("mid_plot_before_rst", int'(plot), 1);
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("rst_mid_plot", int'(plot), 0);
        chk("rst_mid_busy", int'(busy), 0);
        p0 = plot_q.size();
        repeat (5) @(negedge clock);
        chk("rst_mid_no_plots", plot_q.size() - p0, 0);
        $display("mid-draw reset: plot %0d busy %0d", plot, busy);
        m_valid = 1'b0;
        run_vec(7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/obj_draw_ctrl.md
Name: obj_draw_ctrl

Overview:
- Pixel-sequencing stage that sits directly downstream of the object datapath and directly upstream of the VGA adapter.
- Accepts a "place object at (x,y)" request via a req/ack handshake.
- Erases the object's previously drawn OBJ_W x OBJ_H box with the background colour, then draws the box at the new position, emitting one registered plot per clock.
- Tracks the last drawn position internally, so upstream only supplies the new top-left corner.

Parameters:
- OBJ_W, 4, object width in pixels (1..16)
- OBJ_H, 4, object height in pixels (1..16)
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are suppressed
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are suppressed
- BG_COLOUR, 3'd0, colour used for erase

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-low reset
- req  in  1  request; held high by upstream until ack
- req_x  in  8  new top-left x
- req_y  in  7  new top-left y
- req_colour  in  3  draw colour for this request
- req_erase_only  in  1  1 = erase the current object and draw nothing
- ack  out  1  one-cycle pulse when the request is latched
- busy  out  1  high from the cycle after ack until done
- done  out  1  one-cycle pulse after the final pixel cycle
- plot  out  1  pixel write strobe to the VGA adapter
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; ack, busy, done, plot=0; x=0, y=0, colour=0; drawn_valid=0; stored old_x/old_y=0. Reset mid-operation aborts the sequence immediately, with no further plots.
- States: IDLE, ERASE, DRAW, FINISH.
- IDLE + req=1: latch req_x, req_y, req_colour and req_erase_only; assert ack for exactly that cycle.
  - Next state is ERASE if drawn_valid=1.
  - Otherwise next state is DRAW, or FINISH if req_erase_only=1.
- req while busy or in FINISH: ignored, ack=0.
- Pixel counter: col fastest, 0..OBJ_W-1, then row 0..OBJ_H-1. One pixel per clock; OBJ_W*OBJ_H cycles per phase.
- Pixel outputs are registered. For counter (c,r), on the next cycle x=base_x+c and y=base_y+r, computed 9/8-bit wide.
  - plot=1 only if the unwrapped x < SCREEN_W and y < SCREEN_H; otherwise plot=0 and the counter still advances.
- ERASE: base = old position; colour=BG_COLOUR. After the last pixel, go to DRAW, or to FINISH if erase_only.
- DRAW: base = latched new position; colour = latched colour. After the last pixel, go to FINISH.
- FINISH: one cycle. done=1, plot=0.
  - old_x/old_y update to the new position if a draw occurred.
  - drawn_valid = 1 if a draw occurred, 0 if erase_only.
  - Then return to IDLE.
- busy=1 in ERASE, DRAW and FINISH.
- Latency with OBJ 4x4: ack at cycle N; first plot at N+2; done at N+34 with erase, or N+18 without erase.
- erase_only with drawn_valid=0: IDLE, then FINISH, then done; no plots.
- x, y and colour hold their last values while plot=0 outside a phase.

Test Plan:
- Reset, then req (10,58) colour 2 -> ack one cycle; 16 plots colour 2 covering x=10..13, y=58..61 in raster order; no erase plots; done at ack+18.
- Second req (11,58) colour 2 -> 16 plots colour 0 at x=10..13, then 16 plots colour 2 at x=11..14; done at ack+34; last plot (14,61).
- Req (158,118) -> only 4 plots, at (158,118), (159,118), (158,119), (159,119); 12 suppressed cycles; timing unchanged (done at ack+34).
- req held high through busy with changing req_x -> no second ack until after done; the second request is then accepted with its current values.
- req_erase_only after a draw at (20,30) -> 16 plots colour 0 at 20..23/30..33; a following normal req produces no erase phase.
- resetn low during the DRAW phase -> plot=0, busy=0 on the next cycle; the next req draws without an erase phase.
